// File: rtl/add_stream_pkg.sv
// Shared constants and types for the valid/ready wrapper around the
// fixed-latency 32-bit pipelined adder.
package add_stream_pkg;

  // Must agree with the adder's pipeline: input register plus output register.
  localparam int ADD_WIDTH   = 32;
  localparam int ADD_LATENCY = 2;

  typedef logic [ADD_WIDTH-1:0] add_word_t;

endpackage

// File: rtl/add_result_fifo.sv
// Result FIFO for the adder stream adapter. DEPTH need not be a power of
// two; pointers wrap explicitly at DEPTH-1.
module add_result_fifo
  import add_stream_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  // Qualify the requests: never pop empty, and never overwrite a live entry.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only visible while counted.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Credit accounting upstream makes a push into a full, non-popping FIFO impossible.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push && !pop_ok && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/add_stream_adapter.sv
// Valid/ready front- and back-end around the handshake-free pipelined adder.
// Operands pass straight through to the adder; a valid shift register marks
// which adder outputs belong to accepted beats, and a credit check reserves a
// FIFO slot for every beat in flight so backpressure never drops a result.
module add_stream_adapter
  import add_stream_pkg::*;
#(
  parameter int WIDTH   = ADD_WIDTH,
  parameter int LATENCY = ADD_LATENCY,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  input  logic [WIDTH-1:0] add_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = $clog2(DEPTH + LATENCY + 1);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]   fifo_count;
  logic [SUM_W-1:0]   credit_used;
  logic               accept;
  logic               push;
  logic               pop;

  assign add_x = in_x;
  assign add_y = in_y;

  // Credit from registered state only: entries held plus beats still in the adder.
  // A pop this cycle frees its slot only once the count register updates.
  always_comb begin
    credit_used = SUM_W'(fifo_count);
    for (int i = 0; i < LATENCY; i++) begin
      credit_used = credit_used + SUM_W'(vld_q[i]);
    end
    in_ready = (credit_used < SUM_W'(DEPTH));
  end

  assign accept = in_valid & in_ready;

  // Valid marker travels alongside the beat through the adder pipeline.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  // Clearing the markers on reset hides whatever the adder registers still hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign push      = vld_q[LATENCY-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;

  add_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (add_out),
    .pop       (pop),
    .head_data (out_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_add_stream_adapter.sv
// Directed bench for add_stream_adapter with a two-stage adder model.
module tb_add_stream_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [31:0] add_x;
  logic [31:0] add_y;
  logic [31:0] add_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Pipelined adder: input register, then registered sum. No reset, so stale
  // sums stay in it across an adapter reset.
  logic [31:0] ax_q, ay_q;
  always_ff @(posedge clk) begin
    ax_q    <= add_x;
    ay_q    <= add_y;
    add_out <= ax_q + ay_q;
  end

  add_stream_adapter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_out   (add_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] rx, ry;
  int sent, got, seen;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_rst_vld", {30'b0, dut.vld_q}, 32'd0);
    check("post_rst_count", {29'b0, dut.fifo_count}, 32'd0);

    // Single beat 3+4.
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = 32'd3; in_y = 32'd4;
    check("single_c0_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("single_c1_in_ready", {31'b0, in_ready}, 32'd1);
    check("single_c1_out_valid", {31'b0, out_valid}, 32'd0);
    step();
    check("single_c2_vld1", {31'b0, dut.vld_q[1]}, 32'd1);
    check("single_c2_out_valid", {31'b0, out_valid}, 32'd0);
    check("single_c2_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("single_c3_out_valid", {31'b0, out_valid}, 32'd1);
    check("single_c3_out_data", out_data, 32'd7);
    step();
    check("single_c4_out_valid", {31'b0, out_valid}, 32'd0);
    idle(2);

    // Streaming: 8 back-to-back beats, results 11*i on cycles 3..10.
    out_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_x = c; in_y = 10 * c;
      end else begin
        in_valid = 1'b0;
      end
      check($sformatf("stream_c%0d_in_ready", c), {31'b0, in_ready}, 32'd1);
      if (c >= 3) begin
        check($sformatf("stream_c%0d_out_valid", c), {31'b0, out_valid}, 32'd1);
        check($sformatf("stream_c%0d_out_data", c), out_data, 32'(11 * (c - 3)));
      end else begin
        check($sformatf("stream_c%0d_out_valid", c), {31'b0, out_valid}, 32'd0);
      end
      step();
    end
    check("stream_drained", {31'b0, out_valid}, 32'd0);
    idle(2);

    // Backpressure: only 4 beats fit; in_ready low from cycle 4.
    out_ready = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      in_valid = 1'b1; in_x = 100 + c; in_y = 32'd1000;
      check($sformatf("bp_c%0d_in_ready", c), {31'b0, in_ready}, (c < 4) ? 32'd1 : 32'd0);
      if (c >= 3) begin
        check($sformatf("bp_c%0d_out_valid", c), {31'b0, out_valid}, 32'd1);
        check($sformatf("bp_c%0d_head_stable", c), out_data, 32'd1100);
      end
      step();
    end
    check("bp_c6_count", {29'b0, dut.fifo_count}, 32'd4);
    check("bp_c6_in_ready", {31'b0, in_ready}, 32'd0);
    check("bp_c6_out_data", out_data, 32'd1100);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_c7_in_ready", {31'b0, in_ready}, 32'd1);
    check("bp_c7_count", {29'b0, dut.fifo_count}, 32'd3);
    check("bp_c7_out_data", out_data, 32'd1101);
    step();
    check("bp_c8_out_data", out_data, 32'd1102);
    step();
    check("bp_c9_out_data", out_data, 32'd1103);
    check("bp_c9_out_valid", {31'b0, out_valid}, 32'd1);
    step();
    check("bp_c10_out_valid", {31'b0, out_valid}, 32'd0);
    idle(2);

    // Modulo-2^32 wrap of the sum.
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = 32'hFFFF_FFFF; in_y = 32'd1;
    step();
    in_x = 32'h8000_0000; in_y = 32'h8000_0000;
    step();
    in_valid = 1'b0;
    check("wrap_c2_out_valid", {31'b0, out_valid}, 32'd0);
    step();
    check("wrap_c3_out_valid", {31'b0, out_valid}, 32'd1);
    check("wrap_c3_out_data", out_data, 32'h0000_0000);
    step();
    check("wrap_c4_out_valid", {31'b0, out_valid}, 32'd1);
    check("wrap_c4_out_data", out_data, 32'h0000_0000);
    step();
    check("wrap_c5_out_valid", {31'b0, out_valid}, 32'd0);
    idle(1);

    // 20 beats under random out_ready; order checked against a queue.
    sent = 0;
    got  = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      rx = 32'h0101_0101 * sent + 32'hF000_0007;
      ry = 32'h1234_5678 + 32'h2000_0000 * sent;
      in_valid = (sent < 20);
      in_x = rx; in_y = ry;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_output", out_data, 32'hDEAD_BEEF);
        end else begin
          exp_v = exp_q.pop_front();
          check($sformatf("rand_out_%0d", got), out_data, exp_v);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(rx + ry);
        sent++;
      end
      step();
    end
    in_valid = 1'b0;
    check("rand_all_received", 32'(got), 32'd20);
    out_ready = 1'b1;
    idle(3);
    check("rand_no_extra", {31'b0, out_valid}, 32'd0);

    // Reset mid-flight discards two beats; stale adder contents never surface.
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = 32'd1; in_y = 32'd2;
    step();
    in_x = 32'd10; in_y = 32'd20;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_vld_cleared", {30'b0, dut.vld_q}, 32'd0);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      check($sformatf("midrst_c%0d_out_valid", c), {31'b0, out_valid}, 32'd0);
      check($sformatf("midrst_c%0d_count", c), {29'b0, dut.fifo_count}, 32'd0);
      step();
    end
    in_valid = 1'b1; in_x = 32'd5; in_y = 32'd6;
    step();
    in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        check("midrst_result", out_data, 32'd11);
        seen++;
      end
      step();
    end
    check("midrst_one_output", 32'(seen), 32'd1);
    idle(1);

    // Push and pop in the same cycle at peak occupancy.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_x = 200 + c; in_y = 32'd0;
      step();
    end
    in_valid = 1'b0;
    step();
    check("pp_c5_count", {29'b0, dut.fifo_count}, 32'd3);
    check("pp_c5_vld1", {31'b0, dut.vld_q[1]}, 32'd1);
    check("pp_c5_out_data", out_data, 32'd200);
    out_ready = 1'b1;
    step();
    check("pp_c6_count", {29'b0, dut.fifo_count}, 32'd3);
    check("pp_c6_out_data", out_data, 32'd201);
    step();
    check("pp_c7_count", {29'b0, dut.fifo_count}, 32'd2);
    check("pp_c7_out_data", out_data, 32'd202);
    step();
    check("pp_c8_out_data", out_data, 32'd203);
    step();
    check("pp_c9_out_valid", {31'b0, out_valid}, 32'd0);
    check("pp_c9_in_ready", {31'b0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
